multicycle_control: RTL

- Multicycle main controller for the 32-bit MIPS-subset datapath. It is the producer side of the ALU interface: it drives ALUControl and consumes the ALU zero flag.
- It sequences each instruction through FETCH/DECODE/execute/writeback states and generates every datapath strobe and mux select.
- It sits between the instruction register (opcode/funct fields) and the datapath: PC, memory, register file, ALU and muxes.

---
 rtl/multicycle_control_pkg.sv | 71 +++++++
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control_alu_decoder.sv | 38 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the multicycle MIPS-subset controller:
//               opcodes, R-type functs, ALU operations, mux selects and the
//               controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes driven onto alu_control
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_EQ  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // FSM-to-decoder operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_EQ    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Encoding the state register takes on reset (FETCH)
  localparam logic [3:0] STATE_RESET = 4'd0;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALUWB     = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDIEXEC  = 4'd9,
    S_ADDIWB    = 4'd10,
    S_JUMP      = 4'd11,
    S_BNEBRANCH = 4'd12
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Controller <-> datapath bundle: instruction fields and ALU
//               zero flag in, all strobes and mux selects out.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;

  // Controller side
  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op
  );

  // Datapath side
  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM's ALU operation class plus the R-type funct
//               field onto an ALU control code; flags unsupported functs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  // Unknown functs fall back to add so the ALU still sees a defined code
  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_EQ:    alu_control = ALU_EQ;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle main controller for the MIPS-subset datapath.
//               Moore-decoded strobes/selects per state; pc_en additionally
//               folds in the branch condition from the ALU zero flag.
//               Optional macro CTRL_BNE_EN adds bne (opcode 000101).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = STATE_RESET
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] dec_alu_control;
  logic       funct_illegal;

  logic       pc_write, branch, branch_ne;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (bus.funct),
    .alu_control   (dec_alu_control),
    .funct_illegal (funct_illegal)
  );

  // State register, reset straight back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // ALU operation class depends on state alone, keeping the decoder loop-free
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state_q)
      S_EXECUTE:   alu_op = ALUOP_FUNCT;
      S_BRANCH:    alu_op = ALUOP_EQ;
      S_BNEBRANCH: alu_op = ALUOP_EQ;
      default:     alu_op = ALUOP_ADD;
    endcase
  end

  // Next-state and per-state output decode
  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_d = S_BNEBRANCH;
`else
          OP_BNE:       illegal_op = 1'b1;
`endif
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        illegal_op = funct_illegal;
        state_d    = funct_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
`ifdef CTRL_BNE_EN
      S_BNEBRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        branch_ne = 1'b1;
      end
`endif
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low combinationally while rst_n is low so no strobe
  // can glitch between the reset assertion and the state register update
  always_comb begin
    bus.pc_en       = rst_n & (pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero));
    bus.iord        = rst_n & iord;
    bus.mem_write   = rst_n & mem_write;
    bus.ir_write    = rst_n & ir_write;
    bus.reg_dst     = rst_n & reg_dst;
    bus.mem_to_reg  = rst_n & mem_to_reg;
    bus.reg_write   = rst_n & reg_write;
    bus.alu_src_a   = rst_n & alu_src_a;
    bus.alu_src_b   = rst_n ? alu_src_b : 2'b00;
    bus.pc_src      = rst_n ? pc_src : 2'b00;
    bus.alu_control = rst_n ? dec_alu_control : 3'b000;
    bus.illegal_op  = rst_n & illegal_op;
  end

endmodule
`default_nettype wire
